// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master issues operations; the slave (the adder) returns the status and result.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic             i_sub;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_result;
    logic             o_carry;
    logic             o_overflow;

    modport master (
        output i_start, i_sub, i_a, i_b,
        input  o_busy, o_done, o_result, o_carry, o_overflow
    );

    modport slave (
        input  i_start, i_sub, i_a, i_b,
        output o_busy, o_done, o_result, o_carry, o_overflow
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell with a registered carry,
// operands consumed LSB-first, one bit per clock, followed by a one-cycle done pulse.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_addsub_if.slave s_bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_c;
    logic             r_sub;
    logic             r_carry;
    logic             r_overflow;
    logic             r_busy;
    logic             r_done;

    logic             w_s;
    logic             w_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    assign w_s        = r_a[0] ^ r_b[0] ^ r_c;
    assign w_cout     = maj3(r_a[0], r_b[0], r_c);
    assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    // Control FSM, serial datapath and registered status/result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_result   <= '0;
            r_cnt      <= '0;
            r_c        <= 1'b0;
            r_sub      <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (s_bus.i_start) begin
                        // Subtraction as a + ~b + 1: invert b and seed the carry with 1.
                        r_a     <= s_bus.i_a;
                        r_b     <= s_bus.i_sub ? ~s_bus.i_b : s_bus.i_b;
                        r_c     <= s_bus.i_sub;
                        r_sub   <= s_bus.i_sub;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_c   <= w_cout;
                    r_acc <= w_acc_next;
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // r_c still holds the carry into the MSB on this edge.
                        r_result   <= w_acc_next;
                        r_carry    <= w_cout ^ r_sub;
                        r_overflow <= r_c ^ w_cout;
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign s_bus.o_busy     = r_busy;
    assign s_bus.o_done     = r_done;
    assign s_bus.o_result   = r_result;
    assign s_bus.o_carry    = r_carry;
    assign s_bus.o_overflow = r_overflow;
endmodule
